// File: rtl/regfile_burst_arbiter.sv
// Round-robin owner of the register-file write port; sequences one requester's
// burst of consecutive register writes (up or down) one register per cycle.
module regfile_burst_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 3
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    dir,
    input  logic [5*N-1:0]  base,
    input  logic [LW*N-1:0] len,
    input  logic [DW*N-1:0] wdata,
    output logic [N-1:0]    grant,
    output logic            wr_en,
    output logic [4:0]      wr_regnum,
    output logic [DW-1:0]   wr_data,
    output logic [N-1:0]    done
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [4:0]    cur;
    logic [LW-1:0] cnt;
    logic          d;

    logic          found;
    logic [PW-1:0] idx;
    logic [PW-1:0] win;
    logic [N-1:0]  win_oh;
    logic [4:0]    win_base;
    logic [LW-1:0] win_len;
    logic          win_dir;

    // Round-robin pick: first requester at or after ptr, plus its burst fields.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        win      = '0;
        win_oh   = '0;
        win_base = '0;
        win_len  = '0;
        win_dir  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PW'((32'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (32'(win) == i) begin
                win_oh[i] = 1'b1;
                win_base  = base[5*i +: 5];
                win_len   = len[LW*i +: LW];
                win_dir   = dir[i];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            cur   <= '0;
            cnt   <= '0;
            d     <= 1'b0;
            grant <= '0;
            done  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        cur   <= win_base;
                        cnt   <= win_len;
                        d     <= win_dir;
                        grant <= win_oh;
                        ptr   <= PW'((32'(win) + 1) % N);
                        state <= BURST;
                    end
                end
                BURST: begin
                    cur <= d ? cur + 5'd1 : cur - 5'd1;
                    cnt <= cnt - LW'(1);
                    if (cnt == '0) begin
                        grant <= '0;
                        done  <= grant;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Register 0 is hardwired, so its beat is consumed without a write.
    assign wr_en     = (state == BURST) && (cur != 5'd0);
    assign wr_regnum = (state == BURST) ? cur : 5'd0;

    always_comb begin
        wr_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant[i]) wr_data = wr_data | wdata[DW*i +: DW];
        end
    end

endmodule

// File: tb/tb_regfile_burst_arbiter.sv
// Randomized and directed bench for regfile_burst_arbiter against a
// transaction-level model of round-robin grants and burst register sequences.
module tb_regfile_burst_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 3;

    logic            clock;
    logic            reset;
    logic [N-1:0]    req;
    logic [N-1:0]    dir;
    logic [5*N-1:0]  base;
    logic [LW*N-1:0] len;
    logic [DW*N-1:0] wdata;
    logic [N-1:0]    grant;
    logic            wr_en;
    logic [4:0]      wr_regnum;
    logic [DW-1:0]   wr_data;
    logic [N-1:0]    done;

    int errors = 0;
    int checks = 0;

    logic [4:0]    m_base [N];
    logic [LW-1:0] m_len  [N];
    logic          m_dir  [N];
    int            mptr;
    logic [N-1:0]  last_grant;

    regfile_burst_arbiter #(.N(N), .DW(DW), .LW(LW)) dut (
        .clock(clock), .reset(reset), .req(req), .dir(dir), .base(base),
        .len(len), .wdata(wdata), .grant(grant), .wr_en(wr_en),
        .wr_regnum(wr_regnum), .wr_data(wr_data), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic pack_inputs();
        for (int i = 0; i < N; i++) begin
            base[5*i +: 5]   = m_base[i];
            len[LW*i +: LW]  = m_len[i];
            dir[i]           = m_dir[i];
        end
    endtask

    task automatic rand_wdata();
        for (int i = 0; i < N; i++) wdata[DW*i +: DW] = DW'($urandom);
    endtask

    task automatic rand_fields();
        for (int i = 0; i < N; i++) begin
            m_base[i] = 5'($urandom);
            m_len[i]  = LW'($urandom);
            m_dir[i]  = 1'($urandom);
        end
        pack_inputs();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mptr  = 0;
    endtask

    // Called at a negedge in an IDLE cycle; runs one whole burst and ends in the next IDLE cycle.
    task automatic run_burst(input logic [N-1:0] rq, input bit mutate);
        int w, b, l, r;
        bit dd;
        logic [N-1:0] eg;
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && rq[(mptr + k) % N]) w = (mptr + k) % N;
        end
        b = int'(m_base[w]);
        l = int'(m_len[w]);
        dd = m_dir[w];
        mptr = (w + 1) % N;
        eg = '0;
        eg[w] = 1'b1;
        req = rq;
        rand_wdata();
        @(negedge clock);
        for (int k = 0; k <= l; k++) begin
            rand_wdata();
            #1;
            r = dd ? (b + k) % 32 : (((b - k) % 32) + 32) % 32;
            if (k == 0) last_grant = grant;
            checks++;
            if (grant !== eg) begin
                errors++;
                $display("FAIL beat_grant k=%0d got=%b exp=%b", k, grant, eg);
            end
            checks++;
            if (wr_regnum !== 5'(r)) begin
                errors++;
                $display("FAIL beat_regnum k=%0d got=%0d exp=%0d", k, wr_regnum, r);
            end
            checks++;
            if (wr_en !== (r != 0)) begin
                errors++;
                $display("FAIL beat_wr_en k=%0d reg=%0d got=%b exp=%b", k, r, wr_en, r != 0);
            end
            checks++;
            if (wr_data !== wdata[DW*w +: DW]) begin
                errors++;
                $display("FAIL beat_wr_data k=%0d got=%h exp=%h", k, wr_data, wdata[DW*w +: DW]);
            end
            checks++;
            if (done !== '0) begin
                errors++;
                $display("FAIL beat_done k=%0d got=%b exp=0", k, done);
            end
            if (mutate && k == 1) begin
                req[w]    = 1'b0;
                m_base[w] = 5'($urandom);
                m_len[w]  = LW'($urandom);
                m_dir[w]  = 1'($urandom);
                pack_inputs();
            end
            @(negedge clock);
        end
        #1;
        checks++;
        if (done !== eg || grant !== '0 || wr_en !== 1'b0 || wr_regnum !== 5'd0 || wr_data !== '0) begin
            errors++;
            $display("FAIL done_cycle done=%b exp=%b grant=%b wr_en=%b regnum=%0d data=%h exp_zero",
                     done, eg, grant, wr_en, wr_regnum, wr_data);
        end
        req = '0;
        @(negedge clock);
        checks++;
        if (done !== '0 || grant !== '0 || wr_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after done=%b grant=%b wr_en=%b exp=0", done, grant, wr_en);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = '1;
        rand_fields();
        rand_wdata();
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (grant !== '0 || wr_en !== 1'b0 || done !== '0 || wr_regnum !== 5'd0 || wr_data !== '0) begin
                errors++;
                $display("FAIL reset_outputs grant=%b wr_en=%b done=%b regnum=%0d data=%h exp_zero",
                         grant, wr_en, done, wr_regnum, wr_data);
            end
        end
        reset = 1'b1;
        mptr  = 0;
        run_burst('1, 1'b0);
        checks++;
        if (last_grant !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant got=%b exp=0001", last_grant);
        end
    endtask

    task automatic test_idle();
        req = '0;
        repeat (3) begin
            rand_wdata();
            @(negedge clock);
            checks++;
            if (grant !== '0 || wr_en !== 1'b0 || done !== '0 || wr_data !== '0) begin
                errors++;
                $display("FAIL idle_quiet grant=%b wr_en=%b done=%b data=%h exp_zero",
                         grant, wr_en, done, wr_data);
            end
        end
    endtask

    task automatic test_up_burst();
        m_base[1] = 5'd8; m_dir[1] = 1'b1; m_len[1] = 3'd3;
        pack_inputs();
        run_burst(4'b0010, 1'b0);
        checks++;
        if (last_grant !== 4'b0010) begin
            errors++;
            $display("FAIL up_grant got=%b exp=0010", last_grant);
        end
    endtask

    task automatic test_down_wrap();
        m_base[2] = 5'd2; m_dir[2] = 1'b0; m_len[2] = 3'd3;
        pack_inputs();
        run_burst(4'b0100, 1'b0);
        m_base[0] = 5'd31; m_dir[0] = 1'b1; m_len[0] = 3'd1;
        pack_inputs();
        run_burst(4'b0001, 1'b0);
    endtask

    task automatic test_fairness();
        do_reset();
        for (int i = 0; i < N; i++) m_len[i] = '0;
        pack_inputs();
        for (int g = 0; g < 5; g++) begin
            run_burst(4'b1111, 1'b0);
            checks++;
            if (last_grant !== (4'b0001 << (g % 4))) begin
                errors++;
                $display("FAIL fair_order g=%0d got=%b exp=%b", g, last_grant, 4'b0001 << (g % 4));
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m_len[0] = 3'd7;
        m_base[0] = 5'($urandom);
        pack_inputs();
        req = 4'b0001;
        repeat (3) @(negedge clock);
        checks++;
        if (grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_pre_grant got=%b exp=0001", grant);
        end
        req   = '0;
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (grant !== '0 || wr_en !== 1'b0 || done !== '0) begin
                errors++;
                $display("FAIL mid_reset grant=%b wr_en=%b done=%b exp_zero", grant, wr_en, done);
            end
        end
        reset = 1'b1;
        mptr  = 0;
        run_burst(4'b0011, 1'b0);
        checks++;
        if (last_grant !== 4'b0001) begin
            errors++;
            $display("FAIL mid_ptr_restart got=%b exp=0001", last_grant);
        end
    endtask

    task automatic test_input_change();
        m_base[3] = 5'($urandom); m_len[3] = 3'd2; m_dir[3] = 1'($urandom);
        pack_inputs();
        run_burst(4'b1000, 1'b1);
    endtask

    task automatic test_random();
        logic [N-1:0] rq;
        for (int it = 0; it < 30; it++) begin
            rand_fields();
            rq = N'($urandom_range(1, (1 << N) - 1));
            run_burst(rq, 1'($urandom));
            if (it % 7 == 0) test_idle();
        end
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        dir   = '0;
        base  = '0;
        len   = '0;
        wdata = '0;
        mptr  = 0;
        last_grant = '0;
        test_reset();
        test_idle();
        test_up_burst();
        test_down_wrap();
        test_fairness();
        test_reset_mid_burst();
        test_input_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
